operand_shift_bank: RTL and testbench
=====================================

Name: operand_shift_bank

Overview:
- Parametrised successor to the team's 4-bit register: a DEPTH-stage bank of WIDTH-bit registers with per-stage valid tracking.
- Four modes: hold, parallel load, serial shift and rotate.
- Feeds skewed operand rows and columns into the matrix-multiply PE array.
- Exposes both a serial tap and a parallel view, plus occupancy and full/empty flags, for the sequencing controller.

Parameters:
- WIDTH, 4, bits per stage word.
- DEPTH, 4, number of stages (≥2). Stage 0 is the input end; stage DEPTH-1 is the output end.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset.
- sclr  input  1  synchronous clear; highest priority at the clock edge.
- mode  input  2  00 HOLD, 01 LOAD, 10 SHIFT, 11 ROTATE.
- load_bus  input  WIDTH*DEPTH  parallel load data; stage i = bits [i*WIDTH +: WIDTH].
- ser_in  input  WIDTH  serial word entering stage 0 in SHIFT.
- ser_in_valid  input  1  valid qualifier for ser_in.
- ser_out  output  WIDTH  stage DEPTH-1 data; 0 when that stage is invalid.
- ser_out_valid  output  1  valid bit of stage DEPTH-1.
- par_out  output  WIDTH*DEPTH  all stages, same packing as load_bus; invalid stages read 0.
- occupancy  output  CW  number of valid stages, 0..DEPTH.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.

Behaviour:
- State: data[i] (WIDTH bits) and v[i] (1 bit) for each stage i. All are flops on clk, cleared by clr.
- clr low: all data[i] and v[i] cleared immediately, without waiting for a clock edge. Resulting outputs: ser_out=0, ser_out_valid=0, par_out=0, occupancy=0, full=0, empty=1.
  - clr low mid-operation discards any in-flight shift or rotate.
  - Release of clr takes effect at the next rising edge.
- Priority at each rising edge: sclr > mode.
  - sclr=1: all v[i]=0 and all data[i]=0, regardless of mode.
- HOLD (00): no state change.
- LOAD (01): data[i] <= load_bus slice i; v[i] <= 1 for all i. The bank is full next cycle.
- SHIFT (10):
  - data[0] <= ser_in; v[0] <= ser_in_valid.
  - For i ≥ 1: data[i] <= data[i-1]; v[i] <= v[i-1].
  - The old stage DEPTH-1 word is discarded. There is no back-pressure; the controller must sample ser_out in the same cycle it issues SHIFT.
  - ser_in is captured even when ser_in_valid=0, but is masked on the outputs.
- ROTATE (11):
  - data[0] <= data[DEPTH-1]; v[0] <= v[DEPTH-1].
  - For i ≥ 1: data[i] <= data[i-1]; v[i] <= v[i-1].
  - Occupancy is unchanged. DEPTH consecutive rotates restore the original state.
- Outputs are combinational from registered state only. No input-to-output combinational path exists.
  - Latency from any input to an output is one clock edge.
- Output derivation:
  - occupancy = popcount(v); full and empty are derived from occupancy.
  - Masking: par_out slice i = v[i] ? data[i] : 0. ser_out follows the same rule for stage DEPTH-1.
- Boundary conditions:
  - SHIFT while full with ser_in_valid=1: occupancy stays at DEPTH; the oldest word exits.
  - SHIFT while empty with ser_in_valid=0: no visible change.
  - LOAD while partially full overwrites all stages.
  - Any undefined mode bits (X) in simulation are a bench error; RTL treats them via the default branch as HOLD.

Test Plan:
- Reset: drive clr=0 asynchronously mid-cycle after a LOAD of 16'hFFFF (WIDTH=4, DEPTH=4) -> par_out=16'h0000, occupancy=0, empty=1 and full=0 before the next edge. Outputs stay cleared until clr=1 and a non-HOLD mode is applied.
- LOAD: from empty, mode=01 with load_bus=16'hA5C3 -> after one edge, par_out=16'hA5C3, ser_out=4'hA, ser_out_valid=1, occupancy=4, full=1.
- SHIFT fill: from empty, 4 cycles of SHIFT with ser_in=1,2,3,4 and ser_in_valid=1 -> occupancy 1,2,3,4. ser_out_valid first rises after edge 4 with ser_out=4'h1, and par_out=16'h1234.
- SHIFT drain with bubbles: from the LOAD 16'hA5C3 state, 4 SHIFTs with ser_in_valid=0 -> ser_out sequence A,5,C,3 then 0; occupancy 4,3,2,1,0; empty=1 at the end.
- ROTATE: from 16'hA5C3 -> after 1 edge par_out=16'h5C3A, occupancy=4. After 4 edges total, par_out=16'hA5C3.
- Priority/clear: sclr=1 with mode=01 and load_bus=16'h1111 -> next edge par_out=0, empty=1. Separately, assert clr=0 mid-SHIFT sequence -> immediate clear, and the shifted word is lost.

Source files
------------

// File: rtl/operand_shift_bank_if.sv
// Purpose: control and data bundle for operand_shift_bank (mode, load, serial and status signals).
// Latency: n/a (wires only); every output reflects registered bank state.
// Backpressure: none. The controller samples ser_out in the same cycle it issues SHIFT.
//
// Ports carried:
//   sclr, mode, load_bus, ser_in, ser_in_valid             -> into the bank
//   ser_out, ser_out_valid, par_out, occupancy, full, empty <- out of the bank
interface operand_shift_bank_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     sclr;
    logic [1:0]               mode;
    logic [WIDTH*DEPTH-1:0]   load_bus;
    logic [WIDTH-1:0]         ser_in;
    logic                     ser_in_valid;
    logic [WIDTH-1:0]         ser_out;
    logic                     ser_out_valid;
    logic [WIDTH*DEPTH-1:0]   par_out;
    logic [CW-1:0]            occupancy;
    logic                     full;
    logic                     empty;

    // The sequencing controller drives the bank.
    modport master (
        output sclr, mode, load_bus, ser_in, ser_in_valid,
        input  ser_out, ser_out_valid, par_out, occupancy, full, empty
    );

    // The bank itself.
    modport slave (
        input  sclr, mode, load_bus, ser_in, ser_in_valid,
        output ser_out, ser_out_valid, par_out, occupancy, full, empty
    );
endinterface

// File: rtl/operand_shift_bank.sv
// Purpose: DEPTH-stage bank of WIDTH-bit words with per-stage valid bits; it holds, loads, shifts or rotates.
// Latency: one clock edge from any input to any output. Outputs decode registered state only.
// Backpressure: none. SHIFT always drops the stage DEPTH-1 word, so the consumer samples ser_out first.
//
// Ports: clk (rising edge), clr (asynchronous active-low reset), bus (operand_shift_bank_if.slave).
// Stage 0 is the input end and stage DEPTH-1 is the output end.
// Stage i is packed at bits [i*WIDTH +: WIDTH] on load_bus and par_out.
module operand_shift_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    operand_shift_bank_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;

    // Next-state selection. sclr overrides every mode.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        v_d = v_q;

        if (bus.sclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            v_d = '0;
        end else begin
            case (mode_e'(bus.mode))
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_d[i] = bus.load_bus[i*WIDTH +: WIDTH];
                    end
                    v_d = '1;
                end
                MODE_SHIFT: begin
                    // ser_in is captured even when invalid. The output mask hides it.
                    data_d[0] = bus.ser_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_d[i] = data_q[i-1];
                    end
                    v_d = {v_q[DEPTH-2:0], bus.ser_in_valid};
                end
                MODE_ROTATE: begin
                    data_d[0] = data_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        data_d[i] = data_q[i-1];
                    end
                    v_d = {v_q[DEPTH-2:0], v_q[DEPTH-1]};
                end
                default: begin
                    // HOLD, and any unknown mode in simulation, leaves the state untouched.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            v_q <= v_d;
        end
    end

    // Invalid stages read as zero, so downstream PEs see a clean zero operand in each bubble.
    logic [CW-1:0] occ;

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.par_out[i*WIDTH +: WIDTH] = v_q[i] ? data_q[i] : '0;
            occ = occ + CW'(v_q[i]);
        end
    end

    assign bus.ser_out       = v_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
    assign bus.ser_out_valid = v_q[DEPTH-1];
    assign bus.occupancy     = occ;
    assign bus.full          = (occ == CW'(DEPTH));
    assign bus.empty         = (occ == '0);
endmodule

// File: tb/tb_operand_shift_bank.sv
module tb_operand_shift_bank;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = WIDTH * DEPTH;

    logic clk = 1'b0;
    logic clr;

    operand_shift_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of stage entries, where index 0 is the input end.
    // A shift pushes a word in at the front and drops the word at the back.
    // A rotate moves the back entry to the front.
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t mq[$];

    function automatic void m_clear();
        ent_t e;
        e.v = 1'b0;
        e.d = '0;
        mq = {};
        for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    endfunction

    function automatic void m_apply(input logic s, input logic [1:0] m, input logic [BW-1:0] lb,
                                    input logic [WIDTH-1:0] si, input logic sv);
        ent_t e;
        if (s) begin
            m_clear();
        end else if (m == 2'b01) begin
            mq = {};
            for (int i = 0; i < DEPTH; i++) begin
                e.v = 1'b1;
                e.d = lb[i*WIDTH +: WIDTH];
                mq.push_back(e);
            end
        end else if (m == 2'b10) begin
            e.v = sv;
            e.d = si;
            mq.push_front(e);
            void'(mq.pop_back());
        end else if (m == 2'b11) begin
            e = mq.pop_back();
            mq.push_front(e);
        end
    endfunction

    function automatic logic [BW-1:0] exp_par();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mq[i].v) r[i*WIDTH +: WIDTH] = mq[i].d;
        end
        return r;
    endfunction

    function automatic int exp_occ();
        int n;
        n = 0;
        foreach (mq[i]) if (mq[i].v) n++;
        return n;
    endfunction

    task automatic check_all(input string tag);
        int n;
        n = exp_occ();
        chk({tag, ".par"},  64'(bus.par_out), 64'(exp_par()));
        chk({tag, ".ser"},  64'(bus.ser_out), 64'(mq[DEPTH-1].v ? mq[DEPTH-1].d : 4'h0));
        chk({tag, ".serv"}, 64'(bus.ser_out_valid), 64'(mq[DEPTH-1].v));
        chk({tag, ".occ"},  64'(bus.occupancy), 64'(n));
        chk({tag, ".full"}, 64'(bus.full), 64'(n == DEPTH));
        chk({tag, ".empty"},64'(bus.empty), 64'(n == 0));
    endtask

    // Apply one cycle of inputs, clock it, then check just after the edge.
    task automatic step(input string tag, input logic s, input logic [1:0] m, input logic [BW-1:0] lb,
                        input logic [WIDTH-1:0] si, input logic sv);
        bus.sclr         = s;
        bus.mode         = m;
        bus.load_bus     = lb;
        bus.ser_in       = si;
        bus.ser_in_valid = sv;
        @(posedge clk);
        if (clr) m_apply(s, m, lb, si, sv);
        #1;
        check_all(tag);
    endtask

    logic [WIDTH-1:0] drain_ser [4];
    logic [WIDTH-1:0] v4;

    initial begin
        drain_ser[0] = 4'h5;
        drain_ser[1] = 4'hC;
        drain_ser[2] = 4'h3;
        drain_ser[3] = 4'h0;

        clr              = 1'b0;
        bus.sclr         = 1'b0;
        bus.mode         = 2'b00;
        bus.load_bus     = '0;
        bus.ser_in       = '0;
        bus.ser_in_valid = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        clr = 1'b1;

        // Asynchronous clear in the middle of a cycle, after a full load.
        step("ld_ffff", 1'b0, 2'b01, 16'hFFFF, 4'h0, 1'b0);
        chk("ld_ffff_const", 64'(bus.par_out), 64'h FFFF);
        #2 clr = 1'b0;
        #1;
        chk("arst_par",   64'(bus.par_out), 64'h0);
        chk("arst_occ",   64'(bus.occupancy), 64'h0);
        chk("arst_empty", 64'(bus.empty), 64'h1);
        chk("arst_full",  64'(bus.full), 64'h0);
        m_clear();
        step("arst_hold_ld", 1'b0, 2'b01, 16'hBEEF, 4'h0, 1'b0);
        clr = 1'b1;
        step("arst_rel_hold", 1'b0, 2'b00, 16'hBEEF, 4'h0, 1'b0);

        // LOAD from empty.
        step("load", 1'b0, 2'b01, 16'hA5C3, 4'h0, 1'b0);
        chk("load_par",  64'(bus.par_out), 64'hA5C3);
        chk("load_ser",  64'(bus.ser_out), 64'hA);
        chk("load_serv", 64'(bus.ser_out_valid), 64'h1);
        chk("load_occ",  64'(bus.occupancy), 64'h4);
        chk("load_full", 64'(bus.full), 64'h1);

        // Four rotates bring the bank back to where it started.
        step("rot1", 1'b0, 2'b11, 16'h0, 4'h0, 1'b0);
        chk("rot1_par", 64'(bus.par_out), 64'h5C3A);
        chk("rot1_occ", 64'(bus.occupancy), 64'h4);
        for (int i = 0; i < 3; i++) step("rotn", 1'b0, 2'b11, 16'h0, 4'h0, 1'b0);
        chk("rot4_par", 64'(bus.par_out), 64'hA5C3);

        // Drain the bank by shifting in bubbles.
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 2'b10, 16'h0, 4'hF, 1'b0);
            chk("drain_ser", 64'(bus.ser_out), 64'(drain_ser[i]));
            chk("drain_occ", 64'(bus.occupancy), 64'(3 - i));
        end
        chk("drain_empty", 64'(bus.empty), 64'h1);

        // Fill the bank by shifting in 1, 2, 3 and 4.
        for (int i = 0; i < 4; i++) begin
            v4 = 4'(i + 1);
            step("fill", 1'b0, 2'b10, 16'h0, v4, 1'b1);
            chk("fill_occ",  64'(bus.occupancy), 64'(i + 1));
            chk("fill_serv", 64'(bus.ser_out_valid), 64'(i == 3));
        end
        chk("fill_ser", 64'(bus.ser_out), 64'h1);
        chk("fill_par", 64'(bus.par_out), 64'h1234);

        // SHIFT while full: occupancy stays at DEPTH and the oldest word leaves.
        step("full_shift", 1'b0, 2'b10, 16'h0, 4'h5, 1'b1);
        chk("full_shift_occ", 64'(bus.occupancy), 64'h4);
        chk("full_shift_ser", 64'(bus.ser_out), 64'h2);

        // sclr wins over LOAD.
        step("sclr", 1'b1, 2'b01, 16'h1111, 4'h0, 1'b0);
        chk("sclr_par",   64'(bus.par_out), 64'h0);
        chk("sclr_empty", 64'(bus.empty), 64'h1);

        // SHIFT while empty with an invalid word makes no visible change.
        step("empty_shift", 1'b0, 2'b10, 16'h0, 4'h7, 1'b0);
        chk("empty_shift_par", 64'(bus.par_out), 64'h0);

        // LOAD on a partly full bank overwrites every stage.
        step("part", 1'b0, 2'b10, 16'h0, 4'h9, 1'b1);
        step("part_load", 1'b0, 2'b01, 16'h0F0F, 4'h0, 1'b0);
        chk("part_load_par", 64'(bus.par_out), 64'h0F0F);

        // clr asserted during a shift: the bank clears at once and the shifted word is lost.
        step("ms1", 1'b0, 2'b10, 16'h0, 4'h6, 1'b1);
        bus.ser_in = 4'h8;
        #3 clr = 1'b0;
        #1;
        chk("ms_arst_par", 64'(bus.par_out), 64'h0);
        chk("ms_arst_occ", 64'(bus.occupancy), 64'h0);
        m_clear();
        @(posedge clk);
        #1 clr = 1'b1;
        step("ms_after", 1'b0, 2'b00, 16'h0, 4'h0, 1'b0);

        // Randomised traffic checked against the model, with occasional clears.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 clr = 1'b0;
                m_clear();
                #1;
                check_all("rnd_arst");
                @(posedge clk);
                #1 clr = 1'b1;
            end
            step("rnd", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                 BW'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
